// File: rtl/output_sram_arbiter_if.sv
// Bank-side and SRAM-side signal bundle for the output SRAM arbiter.
// The arbiter connects to the slave modport; the bank and SRAM environment connects to the master modport.
interface output_sram_arbiter_if #(
  parameter int NUM_BANK = 4,
  parameter int FV_BW    = 64,
  parameter int NID_W    = 8
);
  logic [NUM_BANK-1:0]       bank_req;
  logic [NUM_BANK-1:0]       bank_sos;
  logic [NUM_BANK-1:0]       bank_eos;
  logic [NUM_BANK*FV_BW-1:0] bank_data;
  logic [NUM_BANK*NID_W-1:0] bank_node_id;
  logic                      sram_ready;

  logic [NUM_BANK-1:0]       req_grant;
  logic                      sram_wr_en;
  logic [FV_BW-1:0]          sram_wdata;
  logic [NID_W-1:0]          sram_node_id;
  logic                      sram_sos;
  logic                      sram_eos;

  modport slave (
    input  bank_req, bank_sos, bank_eos, bank_data, bank_node_id, sram_ready,
    output req_grant, sram_wr_en, sram_wdata, sram_node_id, sram_sos, sram_eos
  );

  modport master (
    output bank_req, bank_sos, bank_eos, bank_data, bank_node_id, sram_ready,
    input  req_grant, sram_wr_en, sram_wdata, sram_node_id, sram_sos, sram_eos
  );
endinterface

// File: rtl/output_sram_arbiter.sv
// Round-robin burst arbiter: grants one vertex-buffer bank at a time and forwards
// its beats to the output SRAM one cycle after each transfer.
module output_sram_arbiter #(
  parameter int NUM_BANK  = 4,
  parameter int FV_BW     = 64,
  parameter int NID_W     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output_sram_arbiter_if.slave  bus,
  output logic                  busy,
  output logic                  err_overrun
);

  localparam int OWN_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [OWN_W-1:0] LAST_RST  = OWN_W'(NUM_BANK - 1);
  localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(MAX_BEATS - 1);

  logic [0:0]       state;
  logic [OWN_W-1:0] owner;
  logic [OWN_W-1:0] last_owner;
  logic [CNT_W-1:0] beat_cnt;

  logic [2*NUM_BANK-1:0] req_dbl;
  logic [OWN_W-1:0]      rr_pick;
  logic                  rr_found;

  logic             sel_req;
  logic             sel_sos;
  logic             sel_eos;
  logic [FV_BW-1:0] sel_data;
  logic [NID_W-1:0] sel_node;
  logic             transfer;

  assign busy = (state == ST_BURST);

  // Rotating the doubled request vector puts bank last_owner+1 at bit 0,
  // so the first set bit is the round-robin winner.
  // NOTE: every always_comb output gets a default first; a path that leaves one unassigned infers a latch.
  always_comb begin
    req_dbl  = {bus.bank_req, bus.bank_req} >> (int'(last_owner) + 1);
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int k = 0; k < NUM_BANK; k++) begin
      if (!rr_found && req_dbl[k]) begin
        rr_found = 1'b1;
        rr_pick  = OWN_W'((int'(last_owner) + 1 + k) % NUM_BANK);
      end
    end
  end

  always_comb begin
    sel_req  = 1'b0;
    sel_sos  = 1'b0;
    sel_eos  = 1'b0;
    sel_data = '0;
    sel_node = '0;
    for (int i = 0; i < NUM_BANK; i++) begin
      if (owner == OWN_W'(i)) begin
        sel_req  = bus.bank_req[i];
        sel_sos  = bus.bank_sos[i];
        sel_eos  = bus.bank_eos[i];
        sel_data = bus.bank_data[i*FV_BW +: FV_BW];
        sel_node = bus.bank_node_id[i*NID_W +: NID_W];
      end
    end
  end

  // Grant is gated combinationally by sram_ready so a stalled SRAM never sees a beat.
  always_comb begin
    bus.req_grant = '0;
    if (state == ST_BURST && bus.sram_ready) begin
      for (int i = 0; i < NUM_BANK; i++) begin
        bus.req_grant[i] = (owner == OWN_W'(i));
      end
    end
  end

  assign transfer = (state == ST_BURST) && bus.sram_ready && sel_req;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      owner       <= '0;
      last_owner  <= LAST_RST;
      beat_cnt    <= '0;
      err_overrun <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rr_found) begin
            owner    <= rr_pick;
            beat_cnt <= '0;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (transfer) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (sel_eos) begin
              state      <= ST_IDLE;
              last_owner <= owner;
            end else if (beat_cnt == CNT_FINAL) begin
              // Forced release: the stream never ended within the legal burst length.
              err_overrun <= 1'b1;
              state       <= ST_IDLE;
              last_owner  <= owner;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write port: the strobe pulses once per transfer, the payload holds between writes.
  // NOTE: the payload registers are reset too because their post-reset value of zero is visible on the ports.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.sram_wr_en   <= 1'b0;
      bus.sram_wdata   <= '0;
      bus.sram_node_id <= '0;
      bus.sram_sos     <= 1'b0;
      bus.sram_eos     <= 1'b0;
    end else begin
      bus.sram_wr_en <= transfer;
      if (transfer) begin
        bus.sram_wdata   <= sel_data;
        bus.sram_node_id <= sel_node;
        bus.sram_sos     <= sel_sos;
        bus.sram_eos     <= sel_eos;
      end
    end
  end

endmodule

// File: tb/tb_output_sram_arbiter.sv
// Self-checking bench for output_sram_arbiter: a transaction-level reference model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_output_sram_arbiter;

  localparam int NB   = 4;
  localparam int FV   = 64;
  localparam int NW   = 8;
  localparam int MAXB = 16;

  localparam logic [NB-1:0] RR_SEQ [12] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2,
                                            4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8};

  logic clk;
  logic reset;
  logic busy;
  logic err_overrun;

  output_sram_arbiter_if #(.NUM_BANK(NB), .FV_BW(FV), .NID_W(NW)) bus ();

  output_sram_arbiter #(
    .NUM_BANK (NB),
    .FV_BW    (FV),
    .NID_W    (NW),
    .MAX_BEATS(MAXB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .err_overrun(err_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner is -1 when no bank holds the SRAM; writes are recorded as the expected
  // registered outputs for the following cycle.
  int          m_owner;
  int          m_last;
  int          m_beats;
  bit          m_err;
  bit          e_wr;
  logic [FV-1:0] e_data;
  logic [NW-1:0] e_node;
  bit          e_sos;
  bit          e_eos;
  logic [NB-1:0] exp_grant;

  function automatic void model_reset();
    m_owner = -1;
    m_last  = NB - 1;
    m_beats = 0;
    m_err   = 0;
    e_wr    = 0;
    e_data  = '0;
    e_node  = '0;
    e_sos   = 0;
    e_eos   = 0;
  endfunction

  function automatic void model_step();
    e_wr = 0;
    if (m_owner >= 0) begin
      if (bus.sram_ready && bus.bank_req[m_owner]) begin
        e_wr   = 1;
        e_data = bus.bank_data[m_owner*FV +: FV];
        e_node = bus.bank_node_id[m_owner*NW +: NW];
        e_sos  = bus.bank_sos[m_owner];
        e_eos  = bus.bank_eos[m_owner];
        m_beats++;
        if (bus.bank_eos[m_owner]) begin
          m_last  = m_owner;
          m_owner = -1;
        end else if (m_beats == MAXB) begin
          m_err   = 1;
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end else begin
      for (int k = 1; k <= NB; k++) begin
        int b = (m_last + k) % NB;
        if (bus.bank_req[b]) begin
          m_owner = b;
          m_beats = 0;
          break;
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    if (reset === 1'b1) model_step();
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      exp_grant = '0;
      if (m_owner >= 0 && bus.sram_ready) exp_grant[m_owner] = 1'b1;
      check("mon_busy",    busy,             m_owner >= 0);
      check("mon_grant",   bus.req_grant,    exp_grant);
      check("mon_wr_en",   bus.sram_wr_en,   e_wr);
      check("mon_wdata",   bus.sram_wdata,   e_data);
      check("mon_node_id", bus.sram_node_id, e_node);
      check("mon_sos",     bus.sram_sos,     e_sos);
      check("mon_eos",     bus.sram_eos,     e_eos);
      check("mon_err",     err_overrun,      m_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [FV-1:0] wr_data [$];
  logic [NW-1:0] wr_node [$];
  logic          wr_eos  [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.bank_req     = '0;
    bus.bank_sos     = '0;
    bus.bank_eos     = '0;
    bus.bank_data    = '0;
    bus.bank_node_id = '0;
    bus.sram_ready   = 1'b1;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},   bus.req_grant,    '0);
    check({tag, "_wr_en"},   bus.sram_wr_en,   '0);
    check({tag, "_wdata"},   bus.sram_wdata,   '0);
    check({tag, "_node_id"}, bus.sram_node_id, '0);
    check({tag, "_sos"},     bus.sram_sos,     '0);
    check({tag, "_eos"},     bus.sram_eos,     '0);
    check({tag, "_busy"},    busy,             '0);
    check({tag, "_err"},     err_overrun,      '0);
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b0;
    model_reset();
    #1;
    check_all_zero("rst");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // One bank streams nbeats; 'other' adds requests from other banks; the SRAM
  // stalls for stall_len cycles once stall_at beats have gone through.
  task automatic burst(input int bank, input int nbeats, input bit with_eos,
                       input int stall_at, input int stall_len,
                       input logic [NB-1:0] other,
                       input logic [FV-1:0] dbase, input logic [NW-1:0] nbase);
    int sent   = 0;
    int stalls = 0;
    logic [NB-1:0] g;
    wr_data.delete();
    wr_node.delete();
    wr_eos.delete();
    for (int c = 0; c < nbeats + stall_len + 8; c++) begin
      clear_inputs();
      bus.bank_req = other;
      if (sent < nbeats) begin
        bus.bank_req[bank]               = 1'b1;
        bus.bank_sos[bank]               = (sent == 0);
        bus.bank_eos[bank]               = with_eos && (sent == nbeats - 1);
        bus.bank_data[bank*FV +: FV]     = dbase + FV'(sent);
        bus.bank_node_id[bank*NW +: NW]  = nbase + NW'(sent);
      end
      bus.sram_ready = !(sent == stall_at && stalls < stall_len);
      #1;
      g = bus.req_grant;
      if (!bus.sram_ready) begin
        check("stall_grant", g, '0);
        if (stalls > 0) check("stall_wr_en", bus.sram_wr_en, 1'b0);
        stalls++;
      end
      @(posedge clk);
      if (g[bank] && sent < nbeats) sent++;
      #1;
      if (bus.sram_wr_en) begin
        wr_data.push_back(bus.sram_wdata);
        wr_node.push_back(bus.sram_node_id);
        wr_eos.push_back(bus.sram_eos);
      end
      if (sent == nbeats) break;
    end
    check("burst_done", sent, nbeats);
  endtask

  task automatic random_cycle(input int eos_pct);
    for (int i = 0; i < NB; i++) begin
      bus.bank_req[i]              = $urandom_range(0, 1) == 1;
      bus.bank_sos[i]              = $urandom_range(0, 1) == 1;
      bus.bank_eos[i]              = $urandom_range(0, 99) < eos_pct;
      bus.bank_data[i*FV +: FV]    = {$urandom(), $urandom()};
      bus.bank_node_id[i*NW +: NW] = NW'($urandom());
    end
    bus.sram_ready = $urandom_range(0, 3) != 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int sent [NB];
    logic [NB-1:0] g;
    reset = 1'b0;
    clear_inputs();
    model_reset();
    apply_reset();
    check_all_zero("post_rst");

    // Round-robin from reset: two beats per bank, bank 0 first.
    for (int i = 0; i < NB; i++) sent[i] = 0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NB; i++) begin
        bus.bank_req[i]              = sent[i] < 2;
        bus.bank_sos[i]              = sent[i] == 0;
        bus.bank_eos[i]              = sent[i] == 1;
        bus.bank_data[i*FV +: FV]    = {$urandom(), $urandom()};
        bus.bank_node_id[i*NW +: NW] = NW'($urandom());
      end
      bus.sram_ready = 1'b1;
      #1;
      g = bus.req_grant;
      check("rr_grant", g, RR_SEQ[c]);
      @(posedge clk);
      for (int i = 0; i < NB; i++) if (g[i] && sent[i] < 2) sent[i]++;
      #1;
    end
    idle(2);

    // Bank 2, three beats, eos on the last.
    burst(2, 3, 1'b1, -1, 0, '0, 64'hA, 8'd5);
    check("b2_writes", wr_data.size(), 3);
    for (int i = 0; i < 3 && i < wr_data.size(); i++) begin
      check("b2_data", wr_data[i], 64'hA + 64'(i));
      check("b2_node", wr_node[i], 8'd5 + 8'(i));
      check("b2_eos",  wr_eos[i],  i == 2);
    end
    idle(2);

    // Bank 1, eight beats with a four-cycle SRAM stall after beat three.
    burst(1, 8, 1'b1, 3, 4, '0, 64'h100, 8'h20);
    check("stall_writes", wr_data.size(), 8);
    for (int i = 0; i < 8 && i < wr_data.size(); i++) begin
      check("stall_data", wr_data[i], 64'h100 + 64'(i));
      check("stall_node", wr_node[i], 8'h20 + 8'(i));
    end
    idle(2);

    // Bank 3 runs 16 beats without eos while banks 1 and 3 keep requesting.
    burst(3, MAXB, 1'b0, -1, 0, 4'b1010, 64'h5000, 8'h40);
    check("ovr_writes", wr_data.size(), MAXB);
    bus.bank_req = 4'b1010;
    #1;
    check("ovr_err",   err_overrun,   1'b1);
    check("ovr_busy",  busy,          1'b0);
    check("ovr_grant", bus.req_grant, 4'b0000);
    tick();
    #1;
    check("ovr_next_grant", bus.req_grant, 4'b0010);
    check("ovr_next_busy",  busy,          1'b1);
    clear_inputs();
    bus.bank_req[1] = 1'b1;
    bus.bank_eos[1] = 1'b1;
    tick();
    idle(2);

    // Reset during the second beat of a bank 2 burst.
    clear_inputs();
    bus.bank_req = 4'b0100;
    tick();
    tick();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all_zero("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_wr_hold", bus.sram_wr_en, 1'b0);
    reset = 1'b1;
    bus.bank_req = 4'b1001;
    #1;
    check("rel_idle_grant", bus.req_grant, 4'b0000);
    tick();
    #1;
    check("rel_bank0_wins", bus.req_grant, 4'b0001);
    bus.bank_eos = 4'b0001;
    tick();
    idle(2);

    // Randomized traffic under three eos densities.
    for (int c = 0; c < 1000; c++) random_cycle(30);
    for (int c = 0; c < 1000; c++) random_cycle(3);
    for (int c = 0; c < 1000; c++) random_cycle(60);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_sram_arbiter.md
OUTPUT_SRAM_ARBITER -- requirements
Module: output_sram_arbiter

Interface
REQ-001 SHALL have parameter NUM_BANK, default 4, meaning number of vertex-buffer banks (requesters).
REQ-002 SHALL have parameter FV_BW, default 64, meaning per-beat data width (`FV_bandwidth).
REQ-003 SHALL have parameter NID_W, default 8, meaning node-id width ($clog2(`Max_Node_id)).
REQ-004 SHALL have parameter MAX_BEATS, default 16, meaning the longest legal burst in beats.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-007 bank_req  in  NUM_BANK  bank i has a beat pending.
REQ-008 bank_sos  in  NUM_BANK  bank i's pending beat is start of stream.
REQ-009 bank_eos  in  NUM_BANK  bank i's pending beat is end of stream.
REQ-010 bank_data  in  NUM_BANK*FV_BW  beat data; bank i in slice [i*FV_BW +: FV_BW].
REQ-011 bank_node_id  in  NUM_BANK*NID_W  beat node id; bank i in slice [i*NID_W +: NID_W].
REQ-012 sram_ready  in  1  output SRAM can accept a write this cycle.
REQ-013 req_grant  out  NUM_BANK  one-hot-or-zero; bank i may transfer its beat this cycle.
REQ-014 sram_wr_en  out  1  registered write strobe to output SRAM.
REQ-015 sram_wdata  out  FV_BW  registered write data.
REQ-016 sram_node_id  out  NID_W  registered write address (node id).
REQ-017 sram_sos / sram_eos  out  1 each  registered stream markers of the written beat.
REQ-018 busy  out  1  high while state is BURST.
REQ-019 err_overrun  out  1  sticky; burst exceeded MAX_BEATS without eos.

Function
REQ-020 SHALL implement states IDLE and BURST with registers owner (log2 NUM_BANK), last_owner, beat_cnt ($clog2(MAX_BEATS+1)).
REQ-021 In IDLE with any bank_req high, SHALL select the first requesting bank in round-robin order starting at last_owner+1 (mod NUM_BANK), load owner, clear beat_cnt, enter BURST next cycle; req_grant SHALL be 0 in IDLE.
REQ-022 In BURST, req_grant SHALL equal onehot(owner) AND sram_ready (combinational gating); all other bits 0.
REQ-023 A transfer SHALL occur in a cycle where req_grant[owner]=1 and bank_req[owner]=1; beat_cnt increments by 1 per transfer.
REQ-024 On a transfer, the cycle after SHALL show sram_wr_en=1 with owner's data, node_id, sos, eos; otherwise sram_wr_en=0 and data outputs hold last value (latency exactly 1).
REQ-025 Owner's bank_req low in BURST SHALL stall (no transfer, grant held, no state change).
REQ-026 Transfer with bank_eos[owner]=1 SHALL return to IDLE and set last_owner=owner; next grant earliest 2 cycles later (one IDLE bubble).
REQ-027 Transfer making beat_cnt reach MAX_BEATS without eos SHALL set err_overrun, return to IDLE, set last_owner=owner (forced release).
REQ-028 Requests from non-owner banks in BURST SHALL be ignored until IDLE; bank_sos is forwarded only, never checked.
REQ-029 sram_ready low SHALL block transfers without altering owner or beat_cnt.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, owner=0, last_owner=NUM_BANK-1 (bank 0 highest priority), beat_cnt=0, req_grant=0, sram_wr_en=0, sram_wdata=0, sram_node_id=0, sram_sos=0, sram_eos=0, busy=0, err_overrun=0.
REQ-031 Reset mid-burst SHALL abandon the burst with no write issued after reset asserts; err_overrun clears only by reset.

Verification
REQ-032 After reset, bank_req=4'b1111, sram_ready=1 -> bank 0 granted first; each bank sends 2 beats (eos on 2nd) -> grant order 0,1,2,3, one idle cycle between bursts.
REQ-033 Bank 2 burst of 3 beats, node_id 5,6,7, data 0xA,0xB,0xC -> sram_wr_en high 3 cycles, each 1 cycle after transfer, sram_eos=1 only with node_id 7.
REQ-034 sram_ready=0 for 4 cycles mid-burst -> req_grant=0 and no writes during those cycles; burst resumes with no lost or duplicated beat.
REQ-035 Owner streams 16 beats without eos (MAX_BEATS=16) -> err_overrun=1 after 16th transfer, state IDLE, next requester granted.
REQ-036 reset pulled low in 2nd beat of burst -> all outputs 0 immediately; after release bank 0 wins over bank 3 when both request.
